// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the PLL/subsystem reset consumers.
// The sequencer uses the slave modport; whoever drives pll_locked uses master.
interface pll_reset_sequencer_if;
    logic       pll_locked;
    logic       pll_rst;
    logic       sdram_rst_n;
    logic       cam_rst_n;
    logic       vga_rst_n;
    logic       running;
    logic [2:0] seq_state;
    logic [3:0] retry_cnt;
    logic       lock_lost;

    modport master (
        output pll_locked,
        input  pll_rst, sdram_rst_n, cam_rst_n, vga_rst_n, running, seq_state, retry_cnt,
        input  lock_lost
    );

    modport slave (
        input  pll_locked,
        output pll_rst, sdram_rst_n, cam_rst_n, vga_rst_n, running, seq_state, retry_cnt,
        output lock_lost
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Drives the PLL reset, qualifies lock and releases SDRAM, camera and VGA resets in order.
// Every output comes straight from a flop loaded with a decode of the next state.
module pll_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 1000000,
    parameter int unsigned STABLE_CYCLES  = 5000,
    parameter int unsigned SDRAM_TO_CAM   = 2500,
    parameter int unsigned CAM_TO_VGA     = 64,
    parameter int unsigned LOSS_FILTER    = 4,
    parameter int unsigned CNT_W          = 20
) (
    input logic                   refclk,
    input logic                   rst_n,
    pll_reset_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        StPllRst   = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRelSdram = 3'd3,
        StRelCam   = 3'd4,
        StRun      = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] PllRstLast  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] StableLast  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] S2cLast     = CNT_W'(SDRAM_TO_CAM - 1);
    localparam logic [CNT_W-1:0] C2vLast     = CNT_W'(CAM_TO_VGA - 1);
    localparam logic [CNT_W-1:0] LossLast    = CNT_W'(LOSS_FILTER - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic [3:0]       retry_q, retry_d;
    logic             sync_q, lk_q;
    logic             lost_q, lost_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sdram_q, sdram_d;
    logic             cam_q, cam_d;
    logic             vga_q, vga_d;
    logic             run_q, run_d;
    logic             retry_inc;
    logic             in_release;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        loss_d     = '0;
        retry_d    = retry_q;
        lost_d     = 1'b0;
        retry_inc  = 1'b0;
        in_release = 1'b0;

        case (state_q)
            StPllRst: begin
                if (cnt_q == PllRstLast) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (lk_q) begin
                    state_d = StStable;
                end else if (cnt_q == TimeoutLast) begin
                    state_d   = StPllRst;
                    retry_inc = 1'b1;
                end
            end
            StStable: begin
                if (!lk_q) state_d = StWaitLock;
                else if (cnt_q == StableLast) state_d = StRelSdram;
            end
            StRelSdram: begin
                in_release = 1'b1;
                if (cnt_q == S2cLast) state_d = StRelCam;
            end
            StRelCam: begin
                in_release = 1'b1;
                if (cnt_q == C2vLast) state_d = StRun;
            end
            StRun: in_release = 1'b1;
            default: state_d = StPllRst;
        endcase

        // Filtered loss overrides any pending release step
        if (in_release && !lk_q) begin
            if (loss_q == LossLast) begin
                state_d   = StPllRst;
                lost_d    = 1'b1;
                retry_inc = 1'b1;
            end else begin
                loss_d = loss_q + 1'b1;
            end
        end

        if (retry_inc && retry_q != 4'hf) retry_d = retry_q + 4'd1;
        if (state_d != state_q) cnt_d = '0;

        pll_rst_d = (state_d == StPllRst);
        sdram_d   = (state_d == StRelSdram) || (state_d == StRelCam) || (state_d == StRun);
        cam_d     = (state_d == StRelCam) || (state_d == StRun);
        vga_d     = (state_d == StRun);
        run_d     = (state_d == StRun);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StPllRst;
            cnt_q     <= '0;
            loss_q    <= '0;
            retry_q   <= '0;
            sync_q    <= 1'b0;
            lk_q      <= 1'b0;
            lost_q    <= 1'b0;
            pll_rst_q <= 1'b1;
            sdram_q   <= 1'b0;
            cam_q     <= 1'b0;
            vga_q     <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            loss_q    <= loss_d;
            retry_q   <= retry_d;
            sync_q    <= bus.pll_locked;
            lk_q      <= sync_q;
            lost_q    <= lost_d;
            pll_rst_q <= pll_rst_d;
            sdram_q   <= sdram_d;
            cam_q     <= cam_d;
            vga_q     <= vga_d;
            run_q     <= run_d;
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.sdram_rst_n = sdram_q;
    assign bus.cam_rst_n   = cam_q;
    assign bus.vga_rst_n   = vga_q;
    assign bus.running     = run_q;
    assign bus.seq_state   = state_q;
    assign bus.retry_cnt   = retry_q;
    assign bus.lock_lost   = lost_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: scripted vector table, timeout/async-reset sequences and
// random lock toggling, all checked each cycle against a phase/elapsed-time model.
module tb_pll_reset_sequencer;
    localparam int PR  = 4;
    localparam int LT  = 50;
    localparam int SC  = 10;
    localparam int S2C = 6;
    localparam int C2V = 3;
    localparam int LF  = 3;

    logic refclk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    pll_reset_sequencer_if bus_if ();

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (PR),
        .LOCK_TIMEOUT   (LT),
        .STABLE_CYCLES  (SC),
        .SDRAM_TO_CAM   (S2C),
        .CAM_TO_VGA     (C2V),
        .LOSS_FILTER    (LF),
        .CNT_W          (20)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus_if.slave)
    );

    always #5 refclk = ~refclk;

    // Model: phase number, edge at which it was entered, and full lock history.
    int m_phase, m_entry, m_edge, m_retry;
    bit m_lost;
    bit hist[$];
    bit lkh[$];

    function automatic void model_reset();
        m_phase = 0; m_entry = 0; m_edge = 0; m_retry = 0; m_lost = 0;
        hist.delete(); lkh.delete();
    endfunction

    function automatic void model_step(bit p);
        bit lk;
        int el, nxt;
        bit loss;
        m_edge++;
        lk = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
        hist.push_back(p);
        lkh.push_back(lk);
        el = m_edge - m_entry;
        nxt = m_phase;
        m_lost = 0;
        case (m_phase)
            0: if (el == PR) nxt = 1;
            1: if (lk) nxt = 2;
               else if (el == LT) begin nxt = 0; m_retry = (m_retry < 15) ? m_retry + 1 : 15; end
            2: if (!lk) nxt = 1; else if (el == SC) nxt = 3;
            3: if (el == S2C) nxt = 4;
            4: if (el == C2V) nxt = 5;
            default: ;
        endcase
        if (m_phase >= 3 && lkh.size() >= LF) begin
            loss = 1;
            for (int i = 1; i <= LF; i++) if (lkh[lkh.size()-i]) loss = 0;
            if (loss) begin
                nxt = 0; m_lost = 1;
                m_retry = (m_retry < 15) ? m_retry + 1 : 15;
            end
        end
        if (nxt != m_phase) begin m_phase = nxt; m_entry = m_edge; end
    endfunction

    function automatic logic [12:0] dut_vec();
        return {bus_if.pll_rst, bus_if.sdram_rst_n, bus_if.cam_rst_n, bus_if.vga_rst_n,
                bus_if.running, bus_if.seq_state, bus_if.retry_cnt, bus_if.lock_lost};
    endfunction

    function automatic logic [12:0] model_vec();
        logic [2:0] st;
        logic [3:0] rt;
        st = 3'(m_phase);
        rt = 4'(m_retry);
        return {m_phase == 0, m_phase >= 3, m_phase >= 4, m_phase == 5, m_phase == 5,
                st, rt, m_lost};
    endfunction

    task automatic check13(string name, logic [12:0] got, logic [12:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s edge %0d: got %b required %b", name, m_edge, got, exp);
        end
    endtask

    task automatic check_invariants();
        n_cmp++;
        if ((bus_if.vga_rst_n && !bus_if.cam_rst_n) || (bus_if.cam_rst_n && !bus_if.sdram_rst_n)) begin
            n_bad++;
            $display("FAIL release_order edge %0d: sdram/cam/vga got %b%b%b", m_edge,
                     bus_if.sdram_rst_n, bus_if.cam_rst_n, bus_if.vga_rst_n);
        end
        n_cmp++;
        if (bus_if.running !== (bus_if.seq_state == 3'd5)) begin
            n_bad++;
            $display("FAIL running_vs_state edge %0d: running %b state %0d", m_edge,
                     bus_if.running, bus_if.seq_state);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        model_step(bus_if.pll_locked);
        @(negedge refclk);
        check13("model", dut_vec(), model_vec());
        check_invariants();
    endtask

    // Async reset: outputs must take reset values before any clock edge.
    task automatic do_reset(string name);
        @(negedge refclk);
        #1 rst_n = 1'b0;
        #1 check13(name, dut_vec(), 13'b1_0000_000_0000_0);
        @(negedge refclk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit         lock;
        int         n;
        logic [2:0] st;
        logic [3:0] retry;
        logic       lost;
    } vec_t;

    vec_t tbl[$];
    bit   lvl;
    int   len;
    int   guard;

    initial begin
        rst_n = 1'b0;
        bus_if.pll_locked = 1'b0;
        model_reset();
        tbl = '{
            '{0, 10, 3'd1, 4'd0, 1'b0}, '{1, 11, 3'd2, 4'd0, 1'b0},
            '{1, 2, 3'd3, 4'd0, 1'b0},  '{1, 5, 3'd3, 4'd0, 1'b0},
            '{1, 1, 3'd4, 4'd0, 1'b0},  '{1, 2, 3'd4, 4'd0, 1'b0},
            '{1, 1, 3'd5, 4'd0, 1'b0},  '{0, 2, 3'd5, 4'd0, 1'b0},
            '{1, 4, 3'd5, 4'd0, 1'b0},  '{0, 4, 3'd5, 4'd0, 1'b0},
            '{0, 1, 3'd0, 4'd1, 1'b1},  '{1, 5, 3'd2, 4'd1, 1'b0},
            '{0, 1, 3'd2, 4'd1, 1'b0},  '{1, 2, 3'd1, 4'd1, 1'b0},
            '{1, 1, 3'd2, 4'd1, 1'b0},  '{1, 9, 3'd2, 4'd1, 1'b0},
            '{1, 1, 3'd3, 4'd1, 1'b0},  '{1, 9, 3'd5, 4'd1, 1'b0}
        };
        repeat (2) @(negedge refclk);
        check13("reset_state", dut_vec(), 13'b1_0000_000_0000_0);
        rst_n = 1'b1;

        foreach (tbl[r]) begin
            bus_if.pll_locked = tbl[r].lock;
            repeat (tbl[r].n) tick();
            check13($sformatf("row%0d", r),
                    {9'd0, bus_if.seq_state, bus_if.retry_cnt, bus_if.lock_lost},
                    {9'd0, tbl[r].st, tbl[r].retry, tbl[r].lost});
        end

        // Lock never arrives: retry every PR+LT cycles, saturating at 15.
        do_reset("reset_in_run");
        bus_if.pll_locked = 1'b0;
        repeat (PR + LT - 1) tick();
        check13("pre_timeout", {11'd0, bus_if.pll_rst, bus_if.retry_cnt != 0}, 13'd0);
        tick();
        check13("first_timeout", {8'd0, bus_if.pll_rst, bus_if.retry_cnt}, {8'd0, 1'b1, 4'd1});
        repeat (16 * (PR + LT)) tick();
        check13("retry_saturated", {8'd0, bus_if.sdram_rst_n, bus_if.retry_cnt},
                {8'd0, 1'b0, 4'd15});

        // Lock arrives late; async reset while in REL_CAM clears retry_cnt too.
        bus_if.pll_locked = 1'b1;
        guard = 0;
        while (m_phase != 4 && guard < 200) begin tick(); guard++; end
        n_cmp++;
        if (m_phase != 4) begin
            n_bad++;
            $display("FAIL reach_rel_cam: phase %0d required 4", m_phase);
        end
        check13("rel_cam_retry", {9'd0, bus_if.retry_cnt}, 13'd15);
        do_reset("reset_in_rel_cam");

        // Random lock toggling, mostly long high runs with short and occasional long drops.
        for (int s = 0; s < 120; s++) begin
            lvl = ($urandom_range(0, 2) != 0);
            if (lvl) len = $urandom_range(1, 45);
            else if ($urandom_range(0, 4) == 0) len = $urandom_range(20, 70);
            else len = $urandom_range(1, 4);
            bus_if.pll_locked = lvl;
            repeat (len) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
